// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and its benches.
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_NOP   = 7'b0000000;

  localparam logic [2:0] FUNC3_ADD = 3'b000;
  localparam logic [2:0] FUNC3_SUB = 3'b000;
  localparam logic [2:0] FUNC3_AND = 3'b111;
  localparam logic [2:0] FUNC3_OR  = 3'b110;
  localparam logic [2:0] FUNC3_XOR = 3'b100;

  localparam logic [6:0] FUNC7_ADD = 7'b0000000;
  localparam logic [6:0] FUNC7_SUB = 7'b0100000;
  localparam logic [6:0] FUNC7_AND = 7'b0000000;
  localparam logic [6:0] FUNC7_OR  = 7'b0000000;
  localparam logic [6:0] FUNC7_XOR = 7'b0000000;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response channels between requesters, arbiter and ALU.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*7-1:0]    req_opcode;
  logic [NUM_REQ*7-1:0]    req_func7;
  logic [NUM_REQ*3-1:0]    req_func3;
  logic [NUM_REQ*XLEN-1:0] req_op1;
  logic [NUM_REQ*XLEN-1:0] req_op2;
  logic [6:0]              alu_opcode;
  logic [6:0]              alu_func7;
  logic [2:0]              alu_func3;
  logic [XLEN-1:0]         alu_op1;
  logic [XLEN-1:0]         alu_op2;
  logic [XLEN-1:0]         alu_out;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [XLEN-1:0]         resp_data;

  // Requesters plus the ALU instance.
  modport master (
    output req_valid, req_opcode, req_func7, req_func3, req_op1, req_op2, alu_out, resp_ready,
    input  req_ready, alu_opcode, alu_func7, alu_func3, alu_op1, alu_op2, resp_valid, resp_data
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_opcode, req_func7, req_func3, req_op1, req_op2, alu_out, resp_ready,
    output req_ready, alu_opcode, alu_func7, alu_func3, alu_op1, alu_op2, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module alu_rr_picker
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[IDX_W'(j)]) begin
        any_o              = 1'b1;
        idx_o              = IDX_W'(j);
        gnt_o[IDX_W'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one clocked ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add the busy_cycles counter port.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0] busy_cycles
`endif
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam int unsigned CntW = $clog2(ALU_LATENCY + 1);

  arb_state_e         state_q;
  logic [IdxW-1:0]    ptr_q, gnt_idx_q, pick_idx, ptr_nxt;
  logic [NUM_REQ-1:0] pick_gnt, resp_valid_q;
  logic               pick_any;
  logic [CntW-1:0]    lat_cnt_q;
  logic [6:0]         opcode_q, func7_q;
  logic [2:0]         func3_q;
  logic [XLEN-1:0]    op1_q, op2_q, resp_data_q;

  alu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign bus.req_ready  = (state_q == IDLE) ? pick_gnt : '0;
  assign ptr_nxt        = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IdxW'(1);

  assign bus.alu_opcode = opcode_q;
  assign bus.alu_func7  = func7_q;
  assign bus.alu_func3  = func3_q;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_idx_q    <= '0;
      lat_cnt_q    <= '0;
      opcode_q     <= '0;
      func7_q      <= '0;
      func3_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            opcode_q  <= bus.req_opcode[7*32'(pick_idx) +: 7];
            func7_q   <= bus.req_func7[7*32'(pick_idx) +: 7];
            func3_q   <= bus.req_func3[3*32'(pick_idx) +: 3];
            op1_q     <= bus.req_op1[XLEN*32'(pick_idx) +: XLEN];
            op2_q     <= bus.req_op2[XLEN*32'(pick_idx) +: XLEN];
            gnt_idx_q <= pick_idx;
            ptr_q     <= ptr_nxt;
            lat_cnt_q <= '0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // Inputs held ALU_LATENCY+1 cycles; result captured on the last one.
          if (32'(lat_cnt_q) == ALU_LATENCY) begin
            resp_data_q  <= bus.alu_out;
            resp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
            opcode_q     <= '0;
            func7_q      <= '0;
            func3_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            state_q      <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + CntW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready[gnt_idx_q]) begin
            resp_valid_q <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state_q != IDLE) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule
